rx_fifo_ctrl: RTL and testbench

Controller that sequences the 8-bit-in / 128-bit-out receive FIFO for the Cortex-M1 receive path. On the write side it gates the incoming byte stream into the FIFO and pads partial 16-byte words with 0x00 after an idle timeout or a flush request. On the read side it pops 128-bit words and serialises them as four 32-bit beats onto a valid/ready stream toward the CPU-side bus interface. Per-byte keep and end-of-frame marking apply to padded words.

---
 rtl/rx_pkg.sv | 40 ++++
 rtl/rx_pad_queue.sv | 59 +++++
 rtl/rx_fifo_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rx_fifo_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared types and constants for the receive FIFO controller.
// Pad records tie a partial word index to its count of real bytes.
package rx_pkg;

    localparam int BYTES_PER_WORD = 16;
    localparam int BEATS_PER_WORD = 4;

    typedef enum logic {
        W_PASS,
        W_PAD
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BEAT
    } r_state_t;

    typedef struct packed {
        logic [8:0] word_idx;
        logic [3:0] valid_bytes;
    } pad_rec_t;

    function automatic logic [2:0] beats_for(input logic [3:0] nbytes);
        return 3'(({1'b0, nbytes} + 5'd3) >> 2);
    endfunction

    // Byte mask for a final beat holding nbytes (1..4) real bytes.
    function automatic logic [3:0] keep_for(input logic [3:0] nbytes);
        logic [3:0] k;
        unique case (nbytes)
            4'd1:    k = 4'h1;
            4'd2:    k = 4'h3;
            4'd3:    k = 4'h7;
            default: k = 4'hF;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/rx_pad_queue.sv
// rx_pad_queue: small synchronous FIFO of pad records.
// Head is visible combinationally; push and pop in one cycle both apply.
module rx_pad_queue
    import rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  pad_rec_t push_rec,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output pad_rec_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    pad_rec_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic do_push;
    logic do_pop;

    assign full = (count == CAP);
    assign empty = (count == '0);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl: byte-in / 128-bit-out receive FIFO sequencer.
// Pads partial words on idle or flush and serialises words as 32-bit beats.
module rx_fifo_ctrl
    import rx_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1024,
    parameter int PADQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic         flush,
    output logic         fifo_wr_en,
    output logic [7:0]   fifo_wr_data,
    input  logic         fifo_wr_full,
    output logic         fifo_rd_en,
    input  logic [127:0] fifo_rd_data,
    input  logic         fifo_rd_empty,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic [3:0]   out_keep,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] TMO = IW'(IDLE_TIMEOUT);
    localparam logic [3:0] PH_LAST = 4'(BYTES_PER_WORD - 1);

    w_state_t w_state;
    logic [3:0] wr_phase;
    logic [8:0] wr_word;
    logic [IW-1:0] idle_cnt;
    logic flush_pend;

    logic accept;
    logic timed_out;
    logic pad_req;
    logic pad_start;
    logic [3:0] phase_next;

    r_state_t r_state;
    logic [8:0] rd_word;
    logic [127:0] hold;
    logic [1:0] beat;
    logic [2:0] nbeats;
    logic padded;
    logic [3:0] pad_bytes;

    logic padq_full;
    logic padq_empty;
    logic padq_pop;
    pad_rec_t padq_head;
    pad_rec_t padq_rec;

    logic head_hit;
    logic [2:0] first_nb;
    logic first_last;
    logic [3:0] first_keep;
    logic [1:0] next_beat;
    logic next_last;
    logic [3:0] next_keep;
    logic final_beat;

    // Write path is combinational so bytes land in the FIFO with no latency.
    always_comb begin
        in_ready = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_wr_data = 8'h00;
        if (!rst) begin
            unique case (w_state)
                W_PASS: begin
                    in_ready = !fifo_wr_full;
                    fifo_wr_en = in_valid && !fifo_wr_full;
                    fifo_wr_data = in_data;
                end
                W_PAD: begin
                    fifo_wr_en = !fifo_wr_full;
                end
                default: ;
            endcase
        end
    end

    assign accept = in_valid && in_ready;
    assign timed_out = (idle_cnt == TMO);
    assign phase_next = wr_phase + {3'b000, fifo_wr_en};
    assign pad_req = (w_state == W_PASS) && (wr_phase != 4'd0) && !accept
                   && (timed_out || flush || flush_pend);
    assign pad_start = pad_req && !padq_full;
    assign padq_rec = '{word_idx: wr_word, valid_bytes: wr_phase};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_PASS;
            wr_phase <= 4'd0;
            wr_word <= 9'd0;
            idle_cnt <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (fifo_wr_en) begin
                wr_phase <= wr_phase + 4'd1;
                if (wr_phase == PH_LAST) begin
                    wr_word <= wr_word + 9'd1;
                end
            end
            if (accept || wr_phase == 4'd0 || w_state != W_PASS) begin
                idle_cnt <= '0;
            end else if (!timed_out) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            // A flush waits out a full pad queue but dies once the word completes.
            flush_pend <= (w_state == W_PASS) && (flush || flush_pend)
                        && !pad_start && (phase_next != 4'd0);
            unique case (w_state)
                W_PASS: if (pad_start) w_state <= W_PAD;
                W_PAD: if (fifo_wr_en && wr_phase == PH_LAST) w_state <= W_PASS;
                default: w_state <= W_PASS;
            endcase
        end
    end

    rx_pad_queue #(
        .DEPTH(PADQ_DEPTH)
    ) u_padq (
        .clk(clk),
        .rst(rst),
        .push(pad_start),
        .push_rec(padq_rec),
        .pop(padq_pop),
        .full(padq_full),
        .empty(padq_empty),
        .head(padq_head)
    );

    assign fifo_rd_en = !rst && (r_state == R_IDLE) && !fifo_rd_empty;

    assign head_hit = !padq_empty && (padq_head.word_idx == rd_word);
    assign first_nb = head_hit ? beats_for(padq_head.valid_bytes)
                               : 3'(BEATS_PER_WORD);
    assign first_last = head_hit && (first_nb == 3'd1);
    assign first_keep = first_last ? keep_for(padq_head.valid_bytes) : 4'hF;

    assign next_beat = beat + 2'd1;
    assign next_last = padded && ({1'b0, next_beat} + 3'd1 == nbeats);
    assign next_keep = next_last ? keep_for(pad_bytes - {next_beat, 2'b00})
                                 : 4'hF;
    assign final_beat = ({1'b0, beat} + 3'd1 == nbeats);
    assign padq_pop = (r_state == R_BEAT) && out_ready && final_beat && padded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rd_word <= 9'd0;
            hold <= '0;
            beat <= 2'd0;
            nbeats <= 3'd0;
            padded <= 1'b0;
            pad_bytes <= 4'd0;
            out_valid <= 1'b0;
            out_data <= 32'd0;
            out_keep <= 4'd0;
            out_last <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (!fifo_rd_empty) r_state <= R_WAIT;
                end
                R_WAIT: begin
                    hold <= fifo_rd_data;
                    padded <= head_hit;
                    pad_bytes <= padq_head.valid_bytes;
                    nbeats <= first_nb;
                    beat <= 2'd0;
                    out_valid <= 1'b1;
                    out_data <= fifo_rd_data[31:0];
                    out_keep <= first_keep;
                    out_last <= first_last;
                    r_state <= R_BEAT;
                end
                R_BEAT: begin
                    if (out_ready) begin
                        if (final_beat) begin
                            out_valid <= 1'b0;
                            out_last <= 1'b0;
                            rd_word <= rd_word + 9'd1;
                            r_state <= R_IDLE;
                        end else begin
                            beat <= next_beat;
                            out_data <= hold[{next_beat, 5'b00000} +: 32];
                            out_keep <= next_keep;
                            out_last <= next_last;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// tb_rx_fifo_ctrl: directed and random stimulus for rx_fifo_ctrl, checked
// against a byte-queue FIFO and a frame-level expected-beat model.
`timescale 1ns/1ps
module tb_rx_fifo_ctrl;

    localparam int TMO = 16;
    localparam int QD = 4;
    localparam int CAP = 4080;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready;
    logic flush = 1'b0;
    logic fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic fifo_wr_full = 1'b0;
    logic fifo_rd_en;
    logic [127:0] fifo_rd_data = '0;
    logic fifo_rd_empty = 1'b1;
    logic out_valid;
    logic [31:0] out_data;
    logic [3:0] out_keep;
    logic out_last;
    logic out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int pad_cnt = 0;
    int wr_cnt = 0;
    bit rdy_rand = 1'b0;
    bit rdy_dir = 1'b0;
    logic [7:0] fq[$];
    logic [127:0] rd_word_m;
    beat_t exp_q[$];
    bit stall = 1'b0;
    beat_t held;

    rx_fifo_ctrl #(
        .IDLE_TIMEOUT(TMO),
        .PADQ_DEPTH(QD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 8-bit-in / 128-bit-out FIFO; first byte lands in [7:0].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_rd_empty <= 1'b1;
            fifo_wr_full <= 1'b0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() < 16) begin
                    chk("rd_underflow", 64'(fq.size()), 16);
                end else begin
                    for (int i = 0; i < 16; i++) rd_word_m[8*i +: 8] = fq.pop_front();
                    fifo_rd_data <= rd_word_m;
                end
            end
            if (fifo_wr_en) begin
                fq.push_back(fifo_wr_data);
                wr_cnt++;
                if (!in_ready) pad_cnt++;
            end
            fifo_rd_empty <= (fq.size() < 16);
            fifo_wr_full <= (fq.size() >= CAP);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_dir;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_beat", 64'({out_data, out_keep, out_last}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(out_valid), 0);
                end else begin
                    chk("beat", 64'({out_data, out_keep, out_last}),
                        64'(exp_q.pop_front()));
                end
            end
            stall = out_valid && !out_ready;
            held = {out_data, out_keep, out_last};
        end
    end

    // Expected beats for a byte run whose trailing partial word gets padded.
    task automatic expect_frame(input logic [7:0] b[$]);
        int n;
        n = b.size();
        for (int w = 0; w * 16 < n; w++) begin
            int r;
            int nb;
            r = (n - 16 * w > 16) ? 16 : n - 16 * w;
            nb = (r + 3) / 4;
            for (int k = 0; k < nb; k++) begin
                beat_t e;
                e.data = 32'd0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * k + j < r) e.data[8*j +: 8] = b[16 * w + 4 * k + j];
                end
                e.last = (r < 16) && (k == nb - 1);
                e.keep = e.last ? 4'((1 << (r - 4 * k)) - 1) : 4'hF;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!a && n < 200) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!a) chk("send_timeout", 64'(in_ready), 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
    endtask

    // mode 0: no terminator, 1: idle past timeout, 2: flush then idle
    task automatic send_frame(input logic [7:0] b[$], input int mode,
                              input bit gaps);
        foreach (b[i]) begin
            if (gaps) cycles($urandom_range(0, 3));
            send(b[i]);
        end
        if (mode == 2) pulse_flush();
        if (mode != 0) cycles(TMO + 25);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            cycles(1);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic rst_check(input string tag);
        rst = 1'b1;
        #1;
        chk(tag, 64'({in_ready, fifo_wr_en, fifo_rd_en, out_valid, out_last,
                      out_data, out_keep, fifo_wr_data}), 0);
        cycles(2);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic rand_bytes(output logic [7:0] b[$], input int n);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] b[$];
        int p;
        int w0;
        int n;

        #3;
        chk("reset_out", 64'({in_ready, fifo_wr_en, fifo_rd_en, out_valid,
                              out_last, out_data, out_keep, fifo_wr_data}), 0);
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        rdy_dir = 1'b1;
        cycles(2);

        b = {};
        for (int i = 0; i < 16; i++) b.push_back(8'(i));
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        wait_drain(200);

        p = pad_cnt;
        w0 = wr_cnt;
        b = {};
        for (int i = 0; i < 5; i++) b.push_back(8'(8'hA0 + i));
        expect_frame(b);
        send_frame(b, 1, 1'b0);
        wait_drain(200);
        chk("idle_pads", 64'(pad_cnt - p), 11);
        chk("idle_writes", 64'(wr_cnt - w0), 16);

        w0 = wr_cnt;
        pulse_flush();
        cycles(TMO + 10);
        chk("flush0_writes", 64'(wr_cnt - w0), 0);
        rand_bytes(b, 16);
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        wait_drain(200);

        p = pad_cnt;
        rand_bytes(b, 15);
        expect_frame(b);
        send_frame(b, 2, 1'b0);
        wait_drain(200);
        chk("flush15_pads", 64'(pad_cnt - p), 1);

        rdy_dir = 1'b0;
        cycles(2);
        b = {};
        for (int i = 0; i < 4096; i++) b.push_back(8'(i));
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        cycles(3);
        chk("full_in_ready", 64'(in_ready), 0);
        chk("bp_valid", 64'(out_valid), 1);
        chk("bp_pending", 64'(exp_q.size()), 1024);
        rdy_dir = 1'b1;
        wait_drain(8000);

        rdy_dir = 1'b0;
        cycles(2);
        p = pad_cnt;
        for (int k = 0; k < 4; k++) begin
            rand_bytes(b, 1);
            expect_frame(b);
            send_frame(b, 1, 1'b0);
        end
        chk("qfull_pads", 64'(pad_cnt - p), 60);
        p = pad_cnt;
        rand_bytes(b, 1);
        expect_frame(b);
        send_frame(b, 1, 1'b0);
        cycles(10);
        chk("defer_pads", 64'(pad_cnt - p), 0);
        chk("defer_ready", 64'(in_ready), 1);
        rdy_dir = 1'b1;
        wait_drain(500);
        chk("resume_pads", 64'(pad_cnt - p), 15);

        rand_bytes(b, 3);
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        pulse_flush();
        cycles(2);
        chk("wpad_busy", 64'(in_ready), 0);
        rst_check("rst_wpad");

        rdy_dir = 1'b0;
        cycles(2);
        rand_bytes(b, 16);
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            cycles(1);
            n++;
        end
        chk("rbeat_valid", 64'(out_valid), 1);
        rst_check("rst_rbeat");
        rdy_dir = 1'b1;
        cycles(2);
        rand_bytes(b, 16);
        expect_frame(b);
        send_frame(b, 0, 1'b0);
        wait_drain(200);

        rdy_rand = 1'b1;
        for (int s = 0; s < 40; s++) begin
            rand_bytes(b, $urandom_range(1, 40));
            expect_frame(b);
            send_frame(b, $urandom_range(1, 2), 1'b1);
            wait_drain(500);
        end
        rdy_rand = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
